// File: rtl/pc_stack.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pc_stack: program counter with return-address stack (hold/inc/jump/call/ret)|
// | Option: define PC_STACK_OVERWRITE_EN for a circular, never-rejecting stack. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module pc_stack #(
  parameter int             N          = 16,
  parameter int             DEPTH      = 8,
  parameter logic [N-1:0]   RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N-1:0]               in,
  input  logic                       inc,
  input  logic                       load,
  input  logic                       call,
  input  logic                       ret,
  output logic [N-1:0]               out,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int SPW = $clog2(DEPTH+1);
  localparam int PW  = $clog2(DEPTH);

  logic [N-1:0]  stack [DEPTH];
  logic [PW-1:0] top;      // next write slot; wraps modulo DEPTH
  logic [PW-1:0] top_dec;
  logic [N-1:0]  out_inc;
  logic          do_ret;
  logic          do_call;
  logic          push;

  assign full    = (sp == SPW'(DEPTH));
  assign empty   = (sp == '0);
  assign out_inc = out + N'(1);
  assign top_dec = top - PW'(1);

  assign do_ret  = ret && !empty;
  assign do_call = !ret && call;
`ifdef PC_STACK_OVERWRITE_EN
  assign push    = rst_n && do_call;
`else
  assign push    = rst_n && do_call && !full;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      stack[top] <= out_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= RESET_ADDR;
      sp  <= '0;
      top <= '0;
      err <= 1'b0;
    end else if (ret) begin
      if (do_ret) begin
        out <= stack[top_dec];
        sp  <= sp - SPW'(1);
        top <= top_dec;
      end else begin
        err <= 1'b1;
      end
    end else if (call) begin
`ifdef PC_STACK_OVERWRITE_EN
      // When full, the write lands on the oldest slot and the depth stays put.
      out <= in;
      top <= top + PW'(1);
      if (!full) begin
        sp <= sp + SPW'(1);
      end
`else
      if (full) begin
        err <= 1'b1;
      end else begin
        out <= in;
        sp  <= sp + SPW'(1);
        top <= top + PW'(1);
      end
`endif
    end else if (load) begin
      out <= in;
    end else if (inc) begin
      out <= out_inc;
    end
  end

endmodule
`default_nettype wire

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- N-bit program counter with an integrated return-address stack.
- Sits directly downstream of the muxn next-address select. It consumes the muxn output on `in` as the jump/call target and registers the current fetch address on `out`.
- Supports hold, increment, load (jump), call (push return address, then jump) and return (pop into PC).
- First sequential stage built on top of the N-bit gate layer.

Parameters:
- N, 16, address width in bits (N >= 2)
- DEPTH, 8, number of return-address stack entries (DEPTH >= 2, power of two)
- RESET_ADDR, 0, value loaded into `out` on reset

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- in  input  N  target address for load/call
- inc  input  1  increment request
- load  input  1  jump request (out <= in)
- call  input  1  call request (push out+1, out <= in)
- ret  input  1  return request (out <= popped address)
- out  output  N  current program counter (registered)
- sp  output  $clog2(DEPTH+1)  number of valid stack entries (registered)
- full  output  1  sp == DEPTH (combinational from sp)
- empty  output  1  sp == 0 (combinational from sp)
- err  output  1  sticky stack-fault flag (registered)

Behaviour:
- Reset (rst_n == 0 at a rising edge): out = RESET_ADDR, sp = 0, err = 0. Stack storage contents are don't-care; they are never read while invalid. Reset overrides every request in the same cycle.
- Per-cycle priority, highest first: reset > ret > call > load > inc > hold. Exactly one action occurs per cycle. Lower-priority requests in the same cycle are ignored, not queued.
- hold (no request): out, sp and err unchanged.
- inc: out <= out + 1, modulo 2^N (2^N-1 wraps to 0).
- load: out <= in. Stack unchanged.
- call, not full:
  - stack[sp] <= out + 1 (mod 2^N); sp <= sp + 1; out <= in.
  - The return address is the increment of the pre-call out, not of in.
- call, full (base build): out and sp unchanged; no push; err <= 1.
- ret, not empty: out <= stack[sp-1]; sp <= sp - 1.
- ret, empty: out and sp unchanged; err <= 1.
- call and ret asserted together: ret wins. Its empty check uses the pre-edge sp.
- err is sticky: it is set by a fault and cleared only by reset. Faults never corrupt out or sp.
- Latency: every action is visible on out/sp one clock after the requesting edge; full/empty follow sp combinationally.
- Reset mid-call-chain: all pending return addresses are discarded (sp = 0). A ret in the cycle after reset is an empty fault.
- No combinational path from any input to out, sp or err.

Optional Feature:
- Macro: PC_STACK_OVERWRITE_EN
- Defined: the stack is a circular buffer.
  - call when full still jumps (out <= in) and writes the return address over the oldest entry.
  - sp stays at DEPTH; err is NOT set.
  - The subsequent DEPTH rets return the newest DEPTH addresses; the next ret is an empty fault.
  - ret-on-empty still sets err.
- Not defined: base behaviour above (call when full is rejected and sets err).

Test Plan:
- Reset then inc: rst_n=0 one edge, then inc=1 for 3 edges -> out = 0,1,2,3; sp=0; empty=1; err=0. Separately, with out=16'hFFFF, inc -> out=16'h0000.
- Call/return: out=16'h0010, call=1 with in=16'h0200 -> out=16'h0200, sp=1. Then inc twice -> 16'h0202. Then ret -> out=16'h0011, sp=0.
- Nested to full: 8 calls with in=16'h1000..16'h1007 from out=0 -> sp=8, full=1, out=16'h1007. A 9th call with in=16'h2000 -> out=16'h1007, sp=8, err=1 (base). With PC_STACK_OVERWRITE_EN -> out=16'h2000, sp=8, err=0.
- Empty fault: from reset, ret=1 -> out=0, sp=0, err=1. Then load in=16'h0042 -> out=16'h0042, err stays 1 until next reset.
- Priority: with sp=1 (top = 16'h0011) and out=16'h0200, assert ret, call, load, inc together with in=16'h0300 -> out=16'h0011, sp=0. Assert load+inc with in=16'h0300 -> out=16'h0300.
- Reset mid-operation: sp=3, rst_n=0 with call=1 on the same edge -> out=RESET_ADDR, sp=0, err=0. The next ret sets err=1.
